// File: rtl/uart_tx_fifo.sv
// Byte FIFO and issue controller feeding a UART transmitter.
// Buffers up to 2**DEPTH_LOG2 bytes from a bus-side writer and drains them
// one at a time over the transmitter's go/ready handshake.
// Ports:
//   i_clk, i_rst     clock, synchronous active-low reset
//   i_wr, i_wdata    write strobe and byte
//   o_full, o_empty  registered occupancy flags
//   o_count          registered occupancy 0..DEPTH
//   o_overflow       sticky flag, set when a write is dropped
//   i_tx_ready       transmitter idle and able to accept a byte
//   o_tx_go          single-cycle issue request
//   o_tx_data        byte being issued, held after the request
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [7:0]            i_wdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_tx_ready,
    output logic                  o_tx_go,
    output logic [7:0]            o_tx_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_BUSY  = 2'd1,
        S_WAIT_READY = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic          r_tx_go;
    logic [7:0]    r_tx_data;
    state_t        r_state;

    state_t        w_state_next;
    logic          w_pop;
    logic          w_wr_acc;
    logic          w_nonempty;
    logic [CW-1:0] w_count_next;

    // A full FIFO drops the write even if a pop happens on the same edge.
    assign w_wr_acc   = i_wr & ~r_full;
    assign w_nonempty = (r_count != '0);

    // Issue FSM: next state and pop decision.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_tx_ready && w_nonempty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    w_state_next = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (i_tx_ready) begin
                    if (w_nonempty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_WAIT_BUSY;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Occupancy after this edge; flags derive from it so they track o_count.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_wr_acc) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointers, occupancy, flags and transmitter outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_go    <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
            r_tx_go <= w_pop;
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (i_wr && r_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_tx_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + PW'(1);
            end
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_wr_acc) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx_go    = r_tx_go;
    assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int BUSY  = 3;

    logic                i_clk;
    logic                i_rst;
    logic                i_wr;
    logic [7:0]          i_wdata;
    logic                o_full;
    logic                o_empty;
    logic [DEPTH_LOG2:0] o_count;
    logic                o_overflow;
    logic                i_tx_ready;
    logic                o_tx_go;
    logic [7:0]          o_tx_data;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr       (i_wr),
        .i_wdata    (i_wdata),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .i_tx_ready (i_tx_ready),
        .o_tx_go    (o_tx_go),
        .o_tx_data  (o_tx_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: queue of accepted bytes not yet issued, sticky overflow.
    logic [7:0] mq[$];
    bit         m_ovf;
    int         n_cmp;
    int         n_fail;
    int         n_go;
    int         n_acc;
    int         busy;
    bit         ready_en;
    bit         rand_mode;
    bit         prev_go;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance, model the transmitter, check state.
    task automatic step(input bit rst, input bit wr, input logic [7:0] d);
        bit         acc;
        int         size_before;
        logic [7:0] exp_byte;
        i_rst       = ~rst;
        i_wr        = wr;
        i_wdata     = d;
        size_before = mq.size();
        acc = !rst && wr && (size_before < DEPTH);
        if (!rst && wr && !acc) m_ovf = 1'b1;
        if (acc) begin
            mq.push_back(d);
            n_acc++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            check("rst_go", 32'(o_tx_go), 32'd0);
            check("rst_data", 32'(o_tx_data), 32'h00);
        end
        if (o_tx_go === 1'b1) begin
            check("go_while_ready", 32'(i_tx_ready), 32'd1);
            check("go_single_cycle", 32'(prev_go), 32'd0);
            check("go_nonempty", 32'(size_before > 0), 32'd1);
            exp_byte = (mq.size() > 0) ? mq.pop_front() : 8'h00;
            check("tx_data", 32'(o_tx_data), 32'(exp_byte));
            n_go++;
            busy = BUSY;
        end
        prev_go = o_tx_go;
        check("count", 32'(o_count), 32'(mq.size()));
        check("empty", 32'(o_empty), 32'(mq.size() == 0));
        check("full", 32'(o_full), 32'(mq.size() == DEPTH));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        if (busy > 0) busy--;
        i_tx_ready = (busy == 0) && (rand_mode ? ($urandom_range(0, 1) == 1) : ready_en);
        i_wr = 1'b0;
    endtask

    task automatic set_ready(input bit en);
        ready_en   = en;
        rand_mode  = 1'b0;
        i_tx_ready = (busy == 0) && en;
    endtask

    task automatic drain();
        int k;
        k = 0;
        set_ready(1'b1);
        while ((mq.size() > 0 || busy > 0) && k < 400) begin
            step(1'b0, 1'b0, 8'h00);
            k++;
        end
        check("drain_bound", 32'(k < 400), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int go0;
        int wr_done;
        logic [7:0] b;
        n_cmp = 0; n_fail = 0; n_go = 0; n_acc = 0; busy = 0;
        m_ovf = 1'b0; prev_go = 1'b0; ready_en = 1'b0; rand_mode = 1'b0;
        i_rst = 1'b0; i_wr = 1'b0; i_wdata = 8'h00; i_tx_ready = 1'b0;

        // Reset held 3 cycles with a write pending.
        repeat (3) step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b0, 8'h00);
        check("post_rst_count", 32'(o_count), 32'd0);
        check("post_rst_go", 32'(o_tx_go), 32'd0);

        // Single byte: go exactly one cycle, two edges after the write.
        set_ready(1'b1);
        go0 = n_go;
        step(1'b0, 1'b1, 8'hA5);
        check("single_e1_go", 32'(o_tx_go), 32'd0);
        check("single_e1_count", 32'(o_count), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("single_e2_go", 32'(o_tx_go), 32'd1);
        check("single_e2_data", 32'(o_tx_data), 32'hA5);
        step(1'b0, 1'b0, 8'h00);
        check("single_e3_go", 32'(o_tx_go), 32'd0);
        check("single_e3_hold", 32'(o_tx_data), 32'hA5);
        check("single_empty", 32'(o_empty), 32'd1);
        drain();
        check("single_go_count", 32'(n_go - go0), 32'd1);

        // Burst of 16 with transmitter held off, then drain in order.
        set_ready(1'b0);
        go0 = n_go;
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i));
        check("burst_full", 32'(o_full), 32'd1);
        drain();
        check("burst_go_count", 32'(n_go - go0), 32'd16);
        check("burst_no_ovf", 32'(o_overflow), 32'd0);

        // Overflow: 17th byte dropped, sticky flag.
        set_ready(1'b0);
        go0 = n_go;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 254)));
        step(1'b0, 1'b1, 8'hFF);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd16);
        drain();
        check("ovf_go_count", 32'(n_go - go0), 32'd16);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // Write plus pop at full: write dropped, count falls to DEPTH-1.
        set_ready(1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h40 + i));
        set_ready(1'b1);
        step(1'b0, 1'b1, 8'hEE);
        check("full_wr_pop_count", 32'(o_count), 32'd15);
        drain();

        // Clear overflow, then write plus pop at count 5.
        step(1'b1, 1'b0, 8'h00);
        check("rst_clears_ovf", 32'(o_overflow), 32'd0);
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h80 + i));
        set_ready(1'b1);
        step(1'b0, 1'b1, 8'h85);
        check("wr_pop_go", 32'(o_tx_go), 32'd1);
        check("wr_pop_count", 32'(o_count), 32'd5);
        drain();

        // Random ready toggling across 1000 write attempts.
        go0 = n_go;
        n_acc = 0;
        wr_done = 0;
        rand_mode = 1'b1;
        while (wr_done < 1000) begin
            if ($urandom_range(0, 7) == 0) begin
                b = 8'($urandom);
                step(1'b0, 1'b1, b);
                wr_done++;
            end else begin
                step(1'b0, 1'b0, 8'h00);
            end
        end
        drain();
        check("rand_all_sent", 32'(n_go - go0), 32'(n_acc));

        // Reset mid-drain with 8 queued: nothing further issued.
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
        set_ready(1'b1);
        step(1'b0, 1'b0, 8'h00);
        check("mid_go", 32'(o_tx_go), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        check("mid_rst_count", 32'(o_count), 32'd0);
        go0 = n_go;
        repeat (40) step(1'b0, 1'b0, 8'h00);
        check("mid_no_more_go", 32'(n_go), 32'(go0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
